// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared clock display constants, segment codes and digit-index encoding
package clock_pkg;

  localparam int MAX_HRS_DEF = 12;
  localparam int MAX_SEC_DEF = 6;

  // Active-low segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    DIG_HR_TENS = 2'd0,
    DIG_HR_ONES = 2'd1,
    DIG_MIN     = 2'd2,
    DIG_SEC     = 2'd3
  } digit_idx_e;

endpackage

// File: rtl/clock_display_scan_seg7_decode.sv
// rtl/clock_display_scan_seg7_decode.sv - BCD digit to active-low 7-segment code, >9 blanks
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - 4-digit multiplexed hh:m:s display scanner with per-frame snapshot
module clock_display_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int MAX_HRS  = MAX_HRS_DEF,
  parameter int MAX_SEC  = MAX_SEC_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] hrs,
  input  logic [2:0] min,
  input  logic [2:0] sec,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done,
  output logic       invalid
);

  localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [4:0]  MAX_HRS_W = 5'(MAX_HRS);
  localparam logic [3:0]  MAX_SEC_W = 4'(MAX_SEC);

  logic [15:0] div_q, div_d;
  digit_idx_e  idx_q, idx_d;
  logic [3:0]  snap_hrs_q;
  logic [2:0]  snap_min_q, snap_sec_q;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q;
  logic        invalid_q;

  logic        div_wrap, capture, inv, hour_tens;
  logic [3:0]  hour_disp, hour_ones, digit;
  logic [6:0]  seg_dec;

  assign div_wrap = (div_q == DIV_LAST);
  assign capture  = div_wrap && (idx_q == DIG_SEC);
  assign div_d    = div_wrap ? 16'd0 : div_q + 16'd1;
  assign idx_d    = div_wrap ? digit_idx_e'(idx_q + 2'd1) : idx_q;

  // Hour 0 is shown as 12 on a 12-hour face
  assign hour_disp = (snap_hrs_q == 4'd0) ? 4'd12 : snap_hrs_q;
  assign hour_tens = (hour_disp >= 4'd10);
  assign hour_ones = hour_tens ? hour_disp - 4'd10 : hour_disp;

  assign inv = ({1'b0, snap_hrs_q} >= MAX_HRS_W) ||
               ({1'b0, snap_min_q} >= MAX_SEC_W) ||
               ({1'b0, snap_sec_q} >= MAX_SEC_W);

  always_comb begin
    digit = DIGIT_BLANK;
    an_d  = ~(4'b1000 >> idx_q);
    case (idx_q)
      DIG_HR_TENS: digit = hour_tens ? 4'd1 : DIGIT_BLANK;
      DIG_HR_ONES: digit = hour_ones;
      DIG_MIN:     digit = {1'b0, snap_min_q};
      DIG_SEC:     digit = {1'b0, snap_sec_q};
      default:     digit = DIGIT_BLANK;
    endcase
    // A bad snapshot shows dashes on every digit, so tens is never blanked then
    if (!inv && idx_q == DIG_HR_TENS && !hour_tens) an_d = 4'hF;
    seg_d = inv ? SEG_DASH : seg_dec;
    dp_d  = !(idx_q == DIG_HR_ONES && !snap_sec_q[0] && !inv);
  end

  seg7_decode u_seg7_decode (
    .digit_i (digit),
    .seg_o   (seg_dec)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q        <= 16'd0;
      idx_q        <= DIG_HR_TENS;
      snap_hrs_q   <= 4'd0;
      snap_min_q   <= 3'd0;
      snap_sec_q   <= 3'd0;
      an_q         <= 4'hF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      invalid_q    <= inv;
      frame_done_q <= capture;
      if (capture) begin
        snap_hrs_q <= hrs;
        snap_min_q <= min;
        snap_sec_q <= sec;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
  assign invalid    = invalid_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - directed self-checking bench for clock_display_scan
module tb_clock_display_scan;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] hrs;
  logic [2:0] min;
  logic [2:0] sec;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;
  logic       invalid;

  int total = 0;
  int bad   = 0;

  logic [3:0] an_s  [4];
  logic [6:0] seg_s [4];
  logic       dp_s  [4];
  logic       inv_s [4];

  localparam logic [15:0] AN_ALL  = 16'h7BDE;
  localparam logic [15:0] AN_BLNK = 16'hFBDE;
  localparam logic [27:0] SEG_DSH = {7'h3F, 7'h3F, 7'h3F, 7'h3F};

  clock_display_scan #(.SCAN_DIV(4), .MAX_HRS(12), .MAX_SEC(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .hrs        (hrs),
    .min        (min),
    .sec        (sec),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done),
    .invalid    (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_time(input logic [3:0] h, input logic [2:0] m, input logic [2:0] s);
    hrs = h;
    min = m;
    sec = s;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".an"},  32'(an), 32'hF);
    chk({tag, ".seg"}, 32'(seg), 32'h7F);
    chk({tag, ".dp"},  32'(dp), 32'h1);
    chk({tag, ".fd"},  32'(frame_done), 32'h0);
    chk({tag, ".inv"}, 32'(invalid), 32'h0);
  endtask

  // Called just after a capture has been seen (or right after reset release);
  // samples the middle of each of the four digit slots.
  task automatic sample_frame(input int chg_at, input logic [2:0] new_sec);
    int k;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == chg_at) sec = new_sec;
      if (n % 4 == 2) begin
        k        = (n - 2) / 4;
        an_s[k]  = an;
        seg_s[k] = seg;
        dp_s[k]  = dp;
        inv_s[k] = invalid;
      end
      if (n == 8) chk("fd_mid", 32'(frame_done), 32'h0);
    end
    chk("fd_end", 32'(frame_done), 32'h1);
  endtask

  task automatic wait_frame();
    bit found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    if (!found) chk("fd_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] ean, input logic [27:0] eseg,
                             input logic [3:0] edp, input logic einv);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.an%0d", tag, k),  32'(an_s[k]),  32'(ean[15-4*k -: 4]));
      chk($sformatf("%s.seg%0d", tag, k), 32'(seg_s[k]), 32'(eseg[27-7*k -: 7]));
      chk($sformatf("%s.dp%0d", tag, k),  32'(dp_s[k]),  32'(edp[3-k]));
      chk($sformatf("%s.inv%0d", tag, k), 32'(inv_s[k]), 32'(einv));
    end
  endtask

  initial begin
    rstn = 1'b0;
    set_time(4'd0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    rstn = 1'b1;
    sample_frame(0, 3'd0);
    check_frame("zero", AN_ALL, {7'h79, 7'h24, 7'h40, 7'h40}, 4'b1011, 1'b0);

    set_time(4'd0, 3'd3, 3'd4);
    wait_frame();
    sample_frame(0, 3'd0);
    check_frame("h0m3s4", AN_ALL, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011, 1'b0);

    set_time(4'd7, 3'd5, 3'd1);
    wait_frame();
    sample_frame(0, 3'd0);
    check_frame("h7m5s1", AN_BLNK, {7'h7F, 7'h78, 7'h12, 7'h79}, 4'b1111, 1'b0);

    set_time(4'd10, 3'd0, 3'd2);
    wait_frame();
    sample_frame(8, 3'd3);
    check_frame("midchg_cur", AN_ALL, {7'h79, 7'h40, 7'h40, 7'h24}, 4'b1011, 1'b0);
    sample_frame(0, 3'd0);
    check_frame("midchg_nxt", AN_ALL, {7'h79, 7'h40, 7'h40, 7'h30}, 4'b1111, 1'b0);

    set_time(4'd13, 3'd2, 3'd2);
    wait_frame();
    sample_frame(0, 3'd0);
    check_frame("h13", AN_ALL, SEG_DSH, 4'b1111, 1'b1);

    set_time(4'd11, 3'd2, 3'd2);
    wait_frame();
    sample_frame(0, 3'd0);
    check_frame("h11", AN_ALL, {7'h79, 7'h79, 7'h24, 7'h24}, 4'b1011, 1'b0);

    set_time(4'd1, 3'd6, 3'd0);
    wait_frame();
    sample_frame(0, 3'd0);
    check_frame("m6", AN_ALL, SEG_DSH, 4'b1111, 1'b1);

    // Wrap 11:5:5 -> 0:0:0 just after the capture edge; pre-edge values must win
    set_time(4'd11, 3'd5, 3'd5);
    wait_frame();
    repeat (16) @(posedge clk);
    #1;
    set_time(4'd0, 3'd0, 3'd0);
    wait_frame();
    sample_frame(0, 3'd0);
    check_frame("wrap_cap", AN_ALL, {7'h79, 7'h79, 7'h12, 7'h12}, 4'b1111, 1'b0);
    sample_frame(0, 3'd0);
    check_frame("wrap_nxt", AN_ALL, {7'h79, 7'h24, 7'h40, 7'h40}, 4'b1011, 1'b0);

    // Reset asserted while the minute digit is lit
    set_time(4'd7, 3'd5, 3'd1);
    wait_frame();
    repeat (9) @(negedge clk);
    chk("pre_rst.an", 32'(an), 32'hD);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk_reset_outputs("midrst_hold");
    rstn = 1'b1;
    sample_frame(0, 3'd0);
    check_frame("post_rst", AN_ALL, {7'h79, 7'h24, 7'h40, 7'h40}, 4'b1011, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
